alu_wide_seq: RTL and testbench

Two-pass sequencer that executes 64-bit data-processing operations on the shared 32-bit execute-stage ALU. It accepts one 64-bit operation over a valid/ready handshake and drives the ALU twice: low word first, then high word with the carry chained. It registers the 64-bit result and ARM-style NZCV flags and presents them on a valid/ready output handshake. It sits between the long-multiply/accumulate and 64-bit move paths and the ALU instance in the execute stage.

---
 rtl/alu_wide_seq_if.sv | 25 ++
 rtl/alu_wide_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_wide_seq.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_wide_seq_if.sv
// Request/response bundle between a 64-bit operation source and alu_wide_seq.
// master = requester/consumer side; slave = the sequencer.
interface alu_wide_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cmd;
  logic        carry_in;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [3:0]  flags;
  logic        illegal;

  modport master (
    output in_valid, cmd, carry_in, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flags, illegal
  );

  modport slave (
    input  in_valid, cmd, carry_in, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flags, illegal
  );
endinterface

// File: rtl/alu_wide_seq.sv
// Two-pass 64-bit operation sequencer driving a shared 32-bit ALU (low word, then high word).
// NZCV flag logic is built only when ALU_WIDE_SEQ_FLAGS_EN is defined; otherwise flags read 0000.
module alu_wide_seq (
  input  logic          clk,
  input  logic          rst_n,
  alu_wide_seq_if.slave bus,
  output logic [31:0]   alu_val1,
  output logic [31:0]   alu_val2,
  output logic [3:0]    alu_cmd,
  output logic          alu_carry_in,
  input  logic [31:0]   alu_out,
  input  logic          alu_carry_out
);

  localparam logic [3:0] CMD_NONE = 4'b0000;
  localparam logic [3:0] CMD_MOV  = 4'b0001;
  localparam logic [3:0] CMD_ADD  = 4'b0010;
  localparam logic [3:0] CMD_ADC  = 4'b0011;
  localparam logic [3:0] CMD_SUB  = 4'b0100;
  localparam logic [3:0] CMD_SBC  = 4'b0101;
  localparam logic [3:0] CMD_AND  = 4'b0110;
  localparam logic [3:0] CMD_ORR  = 4'b0111;
  localparam logic [3:0] CMD_EOR  = 4'b1000;
  localparam logic [3:0] CMD_MVN  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
      CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_add(input logic [3:0] c);
    is_add = (c == CMD_ADD) || (c == CMD_ADC);
  endfunction

  function automatic logic is_sub(input logic [3:0] c);
    is_sub = (c == CMD_SUB) || (c == CMD_SBC);
  endfunction

  state_e      state_q;
  logic [3:0]  cmd_q;
  logic        cin_q;
  logic        ill_q;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [63:0] result_q;
  logic        illegal_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic [31:0] alu_val1_q;
  logic [31:0] alu_val2_q;
  logic [3:0]  alu_cmd_q;
  logic        alu_cin_q;

  logic [3:0]  hi_cmd_d;
  logic        hi_cin_d;
  logic [63:0] result_hi_d;

  // High-pass ALU command/carry (chains the low-pass carry) and final result.
  always_comb begin
    hi_cmd_d    = cmd_q;
    hi_cin_d    = cin_q;
    result_hi_d = {alu_out, result_q[31:0]};
    if (ill_q) begin
      hi_cmd_d    = CMD_NONE;
      hi_cin_d    = cin_q;
      result_hi_d = 64'd0;
    end else if (is_add(cmd_q)) begin
      hi_cmd_d = CMD_ADC;
      hi_cin_d = alu_carry_out;
    end else if (is_sub(cmd_q)) begin
      // ALU reports borrow, SBC wants not-borrow as its carry input.
      hi_cmd_d = CMD_SBC;
      hi_cin_d = ~alu_carry_out;
    end else begin
      hi_cmd_d = cmd_q;
      hi_cin_d = cin_q;
    end
  end

`ifdef ALU_WIDE_SEQ_FLAGS_EN
  logic [3:0] flags_d;
  logic [3:0] flags_q;
  logic       c_flag_d;
  logic       v_flag_d;

  // NZCV from the assembled 64-bit result and the high-pass ALU carry.
  always_comb begin
    c_flag_d = cin_q;
    v_flag_d = 1'b0;
    if (is_add(cmd_q)) begin
      c_flag_d = alu_carry_out;
      v_flag_d = (a_q[63] == b_q[63]) & (result_hi_d[63] != a_q[63]);
    end else if (is_sub(cmd_q)) begin
      c_flag_d = ~alu_carry_out;
      v_flag_d = (a_q[63] != b_q[63]) & (result_hi_d[63] != a_q[63]);
    end else begin
      c_flag_d = cin_q;
      v_flag_d = 1'b0;
    end
    if (ill_q) begin
      flags_d = 4'b0100;
    end else begin
      flags_d = {result_hi_d[63], (result_hi_d == 64'd0), c_flag_d, v_flag_d};
    end
  end

  assign bus.flags = flags_q;
`else
  assign bus.flags = 4'b0000;
`endif

  // Sequencer FSM with all outputs registered; ALU inputs are loaded one edge ahead of use.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 4'b0000;
      cin_q       <= 1'b0;
      ill_q       <= 1'b0;
      a_q         <= 64'd0;
      b_q         <= 64'd0;
      result_q    <= 64'd0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      alu_val1_q  <= 32'd0;
      alu_val2_q  <= 32'd0;
      alu_cmd_q   <= 4'b0000;
      alu_cin_q   <= 1'b0;
`ifdef ALU_WIDE_SEQ_FLAGS_EN
      flags_q     <= 4'b0000;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            cmd_q      <= bus.cmd;
            cin_q      <= bus.carry_in;
            ill_q      <= ~is_legal(bus.cmd);
            a_q        <= bus.op_a;
            b_q        <= bus.op_b;
            alu_val1_q <= bus.op_a[31:0];
            alu_val2_q <= bus.op_b[31:0];
            alu_cmd_q  <= is_legal(bus.cmd) ? bus.cmd : CMD_NONE;
            alu_cin_q  <= bus.carry_in;
            in_ready_q <= 1'b0;
            state_q    <= ST_LO;
          end
        end
        ST_LO: begin
          result_q[31:0] <= alu_out;
          alu_val1_q     <= a_q[63:32];
          alu_val2_q     <= b_q[63:32];
          alu_cmd_q      <= hi_cmd_d;
          alu_cin_q      <= hi_cin_d;
          state_q        <= ST_HI;
        end
        ST_HI: begin
          result_q    <= result_hi_d;
          illegal_q   <= ill_q;
`ifdef ALU_WIDE_SEQ_FLAGS_EN
          flags_q     <= flags_d;
`endif
          alu_val1_q  <= 32'd0;
          alu_val2_q  <= 32'd0;
          alu_cmd_q   <= 4'b0000;
          alu_cin_q   <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          alu_cmd_q   <= 4'b0000;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;
  assign alu_val1      = alu_val1_q;
  assign alu_val2      = alu_val2_q;
  assign alu_cmd       = alu_cmd_q;
  assign alu_carry_in  = alu_cin_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq: table vectors, random ops against a 64-bit
// reference model, a scoreboard queue, and hand-written reset/back-pressure sequences.
module tb_alu_wide_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] alu_val1, alu_val2, alu_out;
  logic [3:0]  alu_cmd;
  logic        alu_carry_in, alu_carry_out;

  alu_wide_seq_if bus ();

  alu_wide_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .alu_val1      (alu_val1),
    .alu_val2      (alu_val2),
    .alu_cmd       (alu_cmd),
    .alu_carry_in  (alu_carry_in),
    .alu_out       (alu_out),
    .alu_carry_out (alu_carry_out)
  );

`ifdef ALU_WIDE_SEQ_FLAGS_EN
  localparam logic [3:0] FLAG_MASK = 4'hF;
`else
  localparam logic [3:0] FLAG_MASK = 4'h0;
`endif

  // 32-bit execute-stage ALU model: carry_out is carry for ADD/ADC, borrow for SUB/SBC.
  logic [32:0] alu_t;
  always_comb begin
    alu_t = 33'd0;
    case (alu_cmd)
      4'b0001: alu_t = {1'b0, alu_val2};
      4'b1001: alu_t = {1'b0, ~alu_val2};
      4'b0010: alu_t = {1'b0, alu_val1} + {1'b0, alu_val2};
      4'b0011: alu_t = {1'b0, alu_val1} + {1'b0, alu_val2} + {32'd0, alu_carry_in};
      4'b0100: alu_t = {({1'b0, alu_val1} < {1'b0, alu_val2}), alu_val1 - alu_val2};
      4'b0101: alu_t = {({1'b0, alu_val1} < ({1'b0, alu_val2} + {32'd0, ~alu_carry_in})),
                        alu_val1 - alu_val2 - {31'd0, ~alu_carry_in}};
      4'b0110: alu_t = {1'b0, alu_val1 & alu_val2};
      4'b0111: alu_t = {1'b0, alu_val1 | alu_val2};
      4'b1000: alu_t = {1'b0, alu_val1 ^ alu_val2};
      default: alu_t = 33'd0;
    endcase
  end
  assign alu_out       = alu_t[31:0];
  assign alu_carry_out = alu_t[32];

  typedef struct {
    logic [3:0]  cmd;
    logic        cin;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [3:0]  flg;
    logic        ill;
    int          hold;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flg;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic legal(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd9);
  endfunction

  // 64-bit reference of the whole operation.
  function automatic exp_t ref_op(input logic [3:0] c, input logic ci,
                                  input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    logic [64:0] t;
    logic cf, vf;
    t = 65'd0; cf = ci; vf = 1'b0; e.ill = 1'b0;
    case (c)
      4'b0001: t = {1'b0, b};
      4'b1001: t = {1'b0, ~b};
      4'b0010, 4'b0011: begin
        t  = {1'b0, a} + {1'b0, b} + {64'd0, (c == 4'b0011) & ci};
        cf = t[64];
        vf = (a[63] == b[63]) && (t[63] != a[63]);
      end
      4'b0100, 4'b0101: begin
        t  = {1'b0, a} - {1'b0, b} - {64'd0, (c == 4'b0101) & ~ci};
        cf = {1'b0, a} >= ({1'b0, b} + {64'd0, (c == 4'b0101) & ~ci});
        vf = (a[63] != b[63]) && (t[63] != a[63]);
      end
      4'b0110: t = {1'b0, a & b};
      4'b0111: t = {1'b0, a | b};
      4'b1000: t = {1'b0, a ^ b};
      default: e.ill = 1'b1;
    endcase
    e.res = e.ill ? 64'd0 : t[63:0];
    e.flg = (e.ill ? 4'b0100 : {t[63], (t[63:0] == 64'd0), cf, vf}) & FLAG_MASK;
    return e;
  endfunction

  // Expected high-pass ALU command and carry input.
  task automatic exp_hi(input vec_t v, output logic [3:0] hc, output logic hci);
    logic [32:0] lo;
    hc = v.cmd; hci = v.cin;
    if (!legal(v.cmd)) begin
      hc = 4'b0000;
    end else if (v.cmd == 4'b0010 || v.cmd == 4'b0011) begin
      lo  = {1'b0, v.a[31:0]} + {1'b0, v.b[31:0]} + {32'd0, (v.cmd == 4'b0011) & v.cin};
      hc  = 4'b0011;
      hci = lo[32];
    end else if (v.cmd == 4'b0100 || v.cmd == 4'b0101) begin
      hc  = 4'b0101;
      hci = {1'b0, v.a[31:0]} >= ({1'b0, v.b[31:0]} + {32'd0, (v.cmd == 4'b0101) & ~v.cin});
    end
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    int cyc;
    logic [3:0] hc;
    logic hci;
    logic [63:0] r0;
    logic [3:0] f0;
    logic i0;
    exp_hi(v, hc, hci);
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    bus.cmd = v.cmd; bus.carry_in = v.cin; bus.op_a = v.a; bus.op_b = v.b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{v.res, v.flg & FLAG_MASK, v.ill});
    // Garbage while busy must be ignored.
    bus.op_a = {$urandom(), $urandom()};
    bus.op_b = {$urandom(), $urandom()};
    bus.cmd = 4'($urandom_range(0, 15));
    bus.carry_in = ~v.cin;
    cyc = 0;
    while (!bus.out_valid && cyc < 10) begin
      if (cyc == 0) begin
        chk("lo_val1", {32'd0, alu_val1}, {32'd0, v.a[31:0]});
        chk("lo_val2", {32'd0, alu_val2}, {32'd0, v.b[31:0]});
        chk("lo_cmd", {60'd0, alu_cmd}, {60'd0, legal(v.cmd) ? v.cmd : 4'b0000});
        chk("lo_cin", {63'd0, alu_carry_in}, {63'd0, v.cin});
      end else if (cyc == 1) begin
        chk("hi_val1", {32'd0, alu_val1}, {32'd0, v.a[63:32]});
        chk("hi_cmd", {60'd0, alu_cmd}, {60'd0, hc});
        chk("hi_cin", {63'd0, alu_carry_in}, {63'd0, hci});
      end
      chk("in_ready_busy", {63'd0, bus.in_ready}, 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'd2);
    if (sb.size() > 0) e = sb.pop_front();
    chk("result", bus.result, e.res);
    chk("flags", {60'd0, bus.flags}, {60'd0, e.flg});
    chk("illegal", {63'd0, bus.illegal}, {63'd0, e.ill});
    chk("done_alu_cmd", {60'd0, alu_cmd}, 64'd0);
    r0 = bus.result; f0 = bus.flags; i0 = bus.illegal;
    for (int k = 0; k < v.hold; k++) begin
      @(posedge clk); #1;
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("hold_result", bus.result, r0);
      chk("hold_flags_ill", {59'd0, bus.flags, bus.illegal}, {59'd0, f0, i0});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    chk("handoff_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("handoff_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("no_accept", {63'd0, bus.in_ready}, 64'd1);
  endtask

  vec_t tbl[11];
  logic [3:0] ops[10];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    exp_t e;
    int seen;

    tbl[0]  = '{4'b0010, 1'b0, 64'h00000000_FFFFFFFF, 64'd1, 64'h00000001_00000000, 4'b0000, 1'b0, 0};
    tbl[1]  = '{4'b0100, 1'b0, 64'h00000001_00000000, 64'd1, 64'h00000000_FFFFFFFF, 4'b0010, 1'b0, 0};
    tbl[2]  = '{4'b0010, 1'b0, 64'h7FFFFFFF_FFFFFFFF, 64'd1, 64'h80000000_00000000, 4'b1001, 1'b0, 0};
    tbl[3]  = '{4'b1000, 1'b1, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 64'd0, 4'b0110, 1'b0, 0};
    tbl[4]  = '{4'b0000, 1'b0, 64'h11111111_22222222, 64'h33333333_44444444, 64'd0, 4'b0100, 1'b1, 5};
    tbl[5]  = '{4'b1001, 1'b0, 64'd7, 64'd0, 64'hFFFFFFFF_FFFFFFFF, 4'b1000, 1'b0, 0};
    tbl[6]  = '{4'b0101, 1'b0, 64'd5, 64'd3, 64'd1, 4'b0010, 1'b0, 0};
    tbl[7]  = '{4'b0011, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 64'd0, 64'd0, 4'b0110, 1'b0, 2};
    tbl[8]  = '{4'b1111, 1'b1, 64'd9, 64'd9, 64'd0, 4'b0100, 1'b1, 0};
    tbl[9]  = '{4'b0100, 1'b0, 64'd0, 64'd1, 64'hFFFFFFFF_FFFFFFFF, 4'b1000, 1'b0, 0};
    tbl[10] = '{4'b0001, 1'b1, 64'd0, 64'h80000000_00000001, 64'h80000000_00000001, 4'b1010, 1'b0, 0};
    ops = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1100};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.cmd = 4'b0000;
    bus.carry_in = 1'b0; bus.op_a = 64'd0; bus.op_b = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_flags_ill", {59'd0, bus.flags, bus.illegal}, 64'd0);
    chk("rst_alu", {alu_val1, alu_val2}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_op(tbl[i]);

    for (int i = 0; i < 16; i++) begin
      v.cmd = ops[$urandom_range(0, 9)];
      v.cin = 1'($urandom_range(0, 1));
      v.a = {$urandom(), $urandom()};
      v.b = (i % 4 == 0) ? 64'h00000000_FFFFFFFF : {$urandom(), $urandom()};
      e = ref_op(v.cmd, v.cin, v.a, v.b);
      v.res = e.res; v.flg = e.flg; v.ill = e.ill; v.hold = i % 3;
      run_op(v);
    end

    // Reset while the high pass is on the ALU.
    bus.cmd = 4'b0010; bus.carry_in = 1'b0; bus.op_a = 64'h5; bus.op_b = 64'h6;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_hi_cmd", {60'd0, alu_cmd}, 64'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_result", bus.result, 64'd0);
    chk("mid_rst_flags_ill", {59'd0, bus.flags, bus.illegal}, 64'd0);
    chk("mid_rst_alu_vals", {alu_val1, alu_val2}, 64'd0);
    chk("mid_rst_alu_ctl", {59'd0, alu_cmd, alu_carry_in}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("aborted_no_valid", 64'(seen), 64'd0);

    v = '{4'b0011, 1'b1, 64'd1, 64'd1, 64'd3, 4'b0000, 1'b0, 0};
    run_op(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
